// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus CPU: opcodes, sequencer states, IR fields.
// Opcode classification helpers keep decode rules in one place.
package cpu_pkg;

    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_SHR  = 5'h05;
    localparam logic [4:0] OP_SHRA = 5'h06;
    localparam logic [4:0] OP_SHL  = 5'h07;
    localparam logic [4:0] OP_ROR  = 5'h08;
    localparam logic [4:0] OP_ROL  = 5'h09;
    localparam logic [4:0] OP_AND  = 5'h0A;
    localparam logic [4:0] OP_OR   = 5'h0B;
    localparam logic [4:0] OP_ADDI = 5'h0C;
    localparam logic [4:0] OP_ANDI = 5'h0D;
    localparam logic [4:0] OP_ORI  = 5'h0E;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6
    } state_e;

    function automatic logic is_rfmt(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

    function automatic logic is_imm(input logic [4:0] op);
        return (op >= OP_ADDI) && (op <= OP_ORI);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return is_rfmt(op) || is_imm(op);
    endfunction

endpackage

// File: rtl/reg_decoder_4to16.sv
// 4-bit register index plus enable to a 16-bit one-hot select.
module reg_decoder_4to16 (
    input  logic [3:0]  idx_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);

    for (genvar gi = 0; gi < 16; gi++) begin : g_dec
        assign onehot_o[gi] = en_i && (idx_i == 4'(gi));
    end

endmodule

// File: rtl/bus_sequencer.sv
// Fetch/execute control-step sequencer for the single-bus datapath.
// Outputs are decoded from the state register and IR, so one bus source per step.
module bus_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_done,
    output logic [15:0] r_out,
    output logic [15:0] r_in,
    output logic        pc_out,
    output logic        mdr_out,
    output logic        zlow_out,
    output logic        c_out,
    output logic        pc_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        inc_pc,
    output logic        read,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    state_e state_q, state_d;
    logic   in_t1_q;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       op_legal, op_rfmt, op_imm;
    logic       unused_ir;

    assign opcode    = ir[OPC_MSB:OPC_LSB];
    assign ra        = ir[RA_MSB:RA_LSB];
    assign rb        = ir[RB_MSB:RB_LSB];
    assign rc        = ir[RC_MSB:RC_LSB];
    assign unused_ir = ^ir[RC_LSB-1:0];
    assign op_legal  = is_legal(opcode);
    assign op_rfmt   = is_rfmt(opcode);
    assign op_imm    = is_imm(opcode);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            in_t1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // remembers a T1 wait cycle so pc_in fires only once per fetch
            in_t1_q <= (state_q == S_T1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    if (mem_done) state_d = S_T2;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = op_legal ? S_T4 : S_IDLE;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = start ? S_T0 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic       rout_en, rin_en;
    logic [3:0] rout_idx;

    assign rout_en  = ((state_q == S_T3) && op_legal) || ((state_q == S_T4) && op_rfmt);
    assign rout_idx = (state_q == S_T3) ? rb : rc;
    assign rin_en   = (state_q == S_T5);

    reg_decoder_4to16 u_rout_dec (
        .idx_i    (rout_idx),
        .en_i     (rout_en),
        .onehot_o (r_out)
    );

    reg_decoder_4to16 u_rin_dec (
        .idx_i    (ra),
        .en_i     (rin_en),
        .onehot_o (r_in)
    );

    always_comb begin
        pc_out   = 1'b0;
        mdr_out  = 1'b0;
        zlow_out = 1'b0;
        c_out    = 1'b0;
        pc_in    = 1'b0;
        mar_in   = 1'b0;
        mdr_in   = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        z_in     = 1'b0;
        inc_pc   = 1'b0;
        read     = 1'b0;
        alu_op   = OP_ADD;
        done     = 1'b0;
        illegal  = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                zlow_out = 1'b1;
                pc_in    = !in_t1_q;
                read     = 1'b1;
                mdr_in   = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                y_in    = op_legal;
                illegal = !op_legal;
            end
            S_T4: begin
                c_out  = op_imm;
                alu_op = opcode;
                z_in   = 1'b1;
            end
            S_T5: begin
                zlow_out = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
